// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// sum_accumulator : sums BLOCK_LEN accepted adder outputs into one block total
// Revision 1.0
// ============================================================================
module sum_accumulator #(
   parameter int SUM_W     = 7,
   parameter int BLOCK_LEN = 4,
   parameter int ACC_W     = 9,
   parameter int CNT_W     = 3
) (
   input  logic             i_w_clk,
   input  logic             i_w_rst_n,
   input  logic [SUM_W-1:0] i_w_s,
   input  logic             i_w_valid,
   output logic             o_w_ready,
   output logic [ACC_W-1:0] o_w_acc,
   output logic             o_w_ovf,
   output logic [CNT_W-1:0] o_w_cnt,
   output logic             o_w_valid,
   input  logic             i_w_ready
);

   localparam logic [0:0]       ST_ACCUM = 1'b0;
   localparam logic [0:0]       ST_DONE  = 1'b1;
   localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(BLOCK_LEN - 1);

   logic [0:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             w_accept;
   logic [ACC_W:0]   w_sum_ext;
   logic [ACC_W:0]   w_add;

   // One extra bit on the add captures the carry out of the accumulator.
   assign w_sum_ext = {{(ACC_W + 1 - SUM_W){1'b0}}, i_w_s};
   assign w_add     = {1'b0, acc_q} + w_sum_ext;
   assign w_accept  = i_w_valid && (state_q == ST_ACCUM);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (state_q == ST_ACCUM) begin
         if (w_accept) begin
            acc_d = w_add[ACC_W-1:0];
            ovf_d = ovf_q | w_add[ACC_W];
            if (cnt_q == C_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end else begin
         if (i_w_ready) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_ACCUM;
         end
      end
   end

   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // All outputs come straight from registers; no input-to-output path.
   assign o_w_ready = (state_q == ST_ACCUM);
   assign o_w_valid = (state_q == ST_DONE);
   assign o_w_acc   = acc_q;
   assign o_w_ovf   = ovf_q;
   assign o_w_cnt   = cnt_q;

endmodule
`default_nettype wire
